count_pwm_gen: RTL

//  Downstream consumer of the free-running sync_counter count.

---
 rtl/count_pwm_gen_pkg.sv | 8 +
 rtl/count_pwm_gen_if.sv | 10 +
 rtl/count_pwm_gen_duty.sv | 43 ++++
 rtl/count_pwm_gen.sv | 58 +++++
 4 files changed

// File: rtl/count_pwm_gen_pkg.sv
// count_pwm_pkg: shared widths, limits and types for the count-driven PWM generator
package count_pwm_pkg;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = 2**CNT_W - 1;
  localparam int DUTY_FULL = 2**CNT_W;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0] duty_t;
endpackage

// File: rtl/count_pwm_gen_if.sv
// count_pwm_gen_if: valid/ready channel carrying new duty values
interface count_pwm_gen_if #(
  parameter int CNT_W = count_pwm_pkg::CNT_W
);
  logic duty_valid;
  logic [CNT_W:0] duty_data;
  logic duty_ready;
  modport master (output duty_valid, duty_data, input duty_ready);
  modport slave (input duty_valid, duty_data, output duty_ready);
endinterface

// File: rtl/count_pwm_gen_duty.sv
// duty_shadow_reg: one-deep pending duty slot, saturation and apply-on-wrap
module duty_shadow_reg
  import count_pwm_pkg::*;
#(
  parameter int CNT_W = count_pwm_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           duty_valid,
  input  logic [CNT_W:0] duty_data,
  output logic           duty_ready,
  input  logic           wrap,
  output logic [CNT_W:0] duty_active,
  output logic [CNT_W:0] duty_eff
);
  localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};
  logic [CNT_W:0] duty_pend_q, duty_pend_d, duty_active_q, duty_active_d;
  logic pend_vld_q, pend_vld_d;
  logic xfer, apply;
  // a slot freed at a wrap only reopens next cycle, so a wrap-cycle offer never bypasses
  always_comb begin
    xfer = duty_valid && !pend_vld_q;
    apply = wrap && pend_vld_q;
    duty_eff = apply ? duty_pend_q : duty_active_q;
    duty_active_d = duty_eff;
    pend_vld_d = xfer || (pend_vld_q && !apply);
    duty_pend_d = xfer ? ((duty_data > FULL) ? FULL : duty_data) : duty_pend_q;
  end
  // pending/active duty pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_pend_q <= '0;
      duty_active_q <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      duty_pend_q <= duty_pend_d;
      duty_active_q <= duty_active_d;
      pend_vld_q <= pend_vld_d;
    end
  end
  assign duty_ready = !pend_vld_q;
  assign duty_active = duty_active_q;
endmodule

// File: rtl/count_pwm_gen.sv
// count_pwm_gen: PWM from an external free-running count, with wrap tick and period counter
module count_pwm_gen
  import count_pwm_pkg::*;
#(
  parameter int CNT_W = count_pwm_pkg::CNT_W,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              en,
  count_pwm_gen_if.slave    duty_if,
  output logic              pwm_out,
  output logic              period_tick,
  output logic [PCNT_W-1:0] period_cnt,
  output logic [CNT_W:0]    duty_active
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PCNT_W-1:0] period_cnt_q, period_cnt_d;
  logic pwm_q, pwm_d, tick_q, tick_d;
  logic wrap;
  logic [CNT_W:0] duty_eff;
  duty_shadow_reg #(.CNT_W(CNT_W)) u_duty (
    .clk         (clk),
    .rst         (rst),
    .duty_valid  (duty_if.duty_valid),
    .duty_data   (duty_if.duty_data),
    .duty_ready  (duty_if.duty_ready),
    .wrap        (wrap),
    .duty_active (duty_active),
    .duty_eff    (duty_eff)
  );
  // a held zero count yields no wrap because cnt_q is then zero too
  always_comb begin
    wrap = en && (cnt_in == '0) && (cnt_q != '0);
    cnt_d = cnt_in;
    pwm_d = en && ({1'b0, cnt_in} < duty_eff);
    tick_d = wrap;
    period_cnt_d = wrap ? period_cnt_q + 1'b1 : period_cnt_q;
  end
  // count history, PWM output and period tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
      tick_q <= 1'b0;
      period_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      tick_q <= tick_d;
      period_cnt_q <= period_cnt_d;
    end
  end
  assign pwm_out = pwm_q;
  assign period_tick = tick_q;
  assign period_cnt = period_cnt_q;
endmodule
